// File: rtl/uart_tx_engine_pkg.sv
// Shared UART definitions: FSM state encoding and baud divisor helpers.
// The RX side imports the same package so both ends agree on timing.
package uart_tx_engine_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } tx_state_e;

   // Clocks per line bit, rounded to nearest.
   function automatic int baud_div(input int freq, input int baud);
      return (freq + baud / 2) / baud;
   endfunction

   function automatic int cnt_width(input int div);
      return (div > 2) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic synchronous FIFO with an explicit occupancy counter.
// Pushes while full and pops while empty are ignored.
module uart_sync_fifo #(
   parameter int data_width = 8,
   parameter int fifo_depth = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push,
   input  logic                        pop,
   input  logic [data_width-1:0]       wdata,
   output logic [data_width-1:0]       rdata,
   output logic                        full,
   output logic                        empty,
   output logic [$clog2(fifo_depth):0] level
);

   localparam int PW = $clog2(fifo_depth);

   if (fifo_depth < 2 || (1 << PW) != fifo_depth) begin : g_depth_chk
      $error("uart_sync_fifo: fifo_depth must be a power of two >= 2");
   end

   logic [data_width-1:0] mem [fifo_depth];
   logic [PW-1:0]         wptr, rptr;
   logic                  do_push, do_pop;

   assign full    = (level == (PW + 1)'(fifo_depth));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end

   // Pointers wrap naturally since the depth is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: FIFO-buffered bytes serialised as start, LSB-first data, stop.
// tx is registered and trails the FSM state by one cycle, so each bit still lasts DIV cycles.
module uart_tx_engine
   import uart_tx_engine_pkg::*;
#(
   parameter int frequency  = 66000000,
   parameter int baudrate   = 115200,
   parameter int data_width = 8,
   parameter int fifo_depth = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [data_width-1:0]       wdata,
   input  logic                        wvalid,
   output logic                        wready,
   output logic                        tx,
   output logic                        busy,
   output logic [$clog2(fifo_depth):0] level
);

   localparam int DIV = baud_div(frequency, baudrate);
   localparam int CW  = cnt_width(DIV);
   localparam int IW  = (data_width > 1) ? $clog2(data_width) : 1;

   if (DIV < 2) begin : g_div_chk
      $error("uart_tx_engine: baud divisor below 2");
   end

   tx_state_e             state;
   logic [CW-1:0]         cnt;
   logic [IW-1:0]         idx;
   logic [data_width-1:0] shreg;
   logic [data_width-1:0] rdata;
   logic                  fifo_full, fifo_empty;
   logic                  busy_q;
   logic                  cnt_end, pop;

   uart_sync_fifo #(
      .data_width (data_width),
      .fifo_depth (fifo_depth)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wvalid),
      .pop   (pop),
      .wdata (wdata),
      .rdata (rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   assign wready  = !fifo_full;
   assign cnt_end = (cnt == CW'(DIV - 1));
   // Only entries already present at this edge can be popped.
   assign pop     = !fifo_empty && ((state == S_IDLE) || (state == S_STOP && cnt_end));
   // busy_q covers the final stop-bit cycle that tx still drives after the FSM is idle.
   assign busy    = busy_q || (state != S_IDLE) || !fifo_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         idx    <= '0;
         shreg  <= '0;
         tx     <= 1'b1;
         busy_q <= 1'b0;
      end else begin
         busy_q <= (state != S_IDLE);
         if (state != S_IDLE) cnt <= cnt_end ? '0 : cnt + 1'b1;
         unique case (state)
            S_IDLE: begin
               tx <= 1'b1;
               if (pop) begin
                  shreg <= rdata;
                  state <= S_START;
               end
            end
            S_START: begin
               tx <= 1'b0;
               if (cnt_end) begin
                  idx   <= '0;
                  state <= S_DATA;
               end
            end
            S_DATA: begin
               tx <= shreg[idx];
               if (cnt_end) begin
                  if (idx == IW'(data_width - 1)) state <= S_STOP;
                  else                            idx   <= idx + 1'b1;
               end
            end
            S_STOP: begin
               tx <= 1'b1;
               if (cnt_end) begin
                  if (pop) begin
                     shreg <= rdata;
                     state <= S_START;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: frame-level reference model checked every cycle,
// a constant table for the single-byte frame, and directed corner sequences.
module tb_uart_tx_engine;

   localparam int FREQ  = 16;
   localparam int BAUD  = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int DIV   = (FREQ + BAUD / 2) / BAUD;
   localparam int FRAME = (DW + 2) * DIV;

   logic          clk = 1'b0;
   logic          rst, wvalid, wready, tx, busy;
   logic [DW-1:0] wdata;
   logic [2:0]    level;

   uart_tx_engine #(
      .frequency  (FREQ),
      .baudrate   (BAUD),
      .data_width (DW),
      .fifo_depth (DEPTH)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .wdata  (wdata),
      .wvalid (wvalid),
      .wready (wready),
      .tx     (tx),
      .busy   (busy),
      .level  (level)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   int cyc = 0;
   bit armed = 0, last_acc = 0, stall_seen = 0;

   // Model: each accepted byte gets a frame start cycle S = max(prev S + FRAME, accept + 2);
   // it leaves the FIFO at edge S-1.
   int            fs[$];
   logic [DW-1:0] fb[$];
   int            last_s = -100000;

   function automatic int m_level();
      int n = 0;
      foreach (fs[i]) if (fs[i] - 1 <= cyc) n++;
      return fs.size() - n;
   endfunction

   function automatic int m_tx();
      int o;
      logic [DW-1:0] b;
      foreach (fs[i]) begin
         if (cyc >= fs[i] && cyc < fs[i] + FRAME) begin
            o = (cyc - fs[i]) / DIV;
            if (o == 0) return 0;
            if (o == DW + 1) return 1;
            b = fb[i];
            return int'(b[o-1]);
         end
      end
      return 1;
   endfunction

   function automatic int m_busy();
      if (m_level() != 0) return 1;
      foreach (fs[i]) if (cyc >= fs[i] - 1 && cyc <= fs[i] + FRAME - 1) return 1;
      return 0;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
      end
   endtask

   task automatic tick();
      bit acc;
      int s;
      acc = !rst && wvalid && (m_level() < DEPTH);
      @(posedge clk);
      cyc++;
      if (rst) begin
         fs.delete();
         fb.delete();
         last_s = -100000;
         armed  = 1;
      end else if (acc) begin
         s = (last_s + FRAME > cyc + 2) ? last_s + FRAME : cyc + 2;
         last_s = s;
         fs.push_back(s);
         fb.push_back(wdata);
      end
      last_acc = acc;
      #1;
      if (armed) begin
         chk("tx", int'(tx), m_tx());
         chk("wready", int'(wready), int'(m_level() < DEPTH));
         chk("level", int'(level), m_level());
         chk("busy", int'(busy), m_busy());
         if (!wready) stall_seen = 1;
      end
   endtask

   // Leaves wvalid high so the caller can stream bytes back to back.
   task automatic push_byte(input logic [DW-1:0] b);
      int g = 0;
      wvalid = 1'b1;
      wdata  = b;
      do begin
         tick();
         g++;
      end while (!last_acc && g < 500);
      if (!last_acc) begin
         n_cmp++;
         n_bad++;
         $display("FAIL push_timeout cyc=%0d byte=%0h never accepted", cyc, b);
      end
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) tick();
   endtask

   task automatic wait_idle();
      int g = 0;
      wvalid = 1'b0;
      while (m_busy() != 0 && g < 2000) begin
         tick();
         g++;
      end
      tick();
      chk("idle_busy", int'(busy), 0);
   endtask

   typedef struct {
      int   at;
      logic tx;
      logic busy;
      int   lvl;
   } vec_t;

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d bench did not complete", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vt[16];
      int   e;

      vt = '{'{0, 1, 1, 1},  '{1, 1, 1, 0},  '{2, 0, 1, 0},  '{5, 0, 1, 0},
             '{6, 1, 1, 0},  '{9, 1, 1, 0},  '{10, 0, 1, 0}, '{14, 1, 1, 0},
             '{18, 0, 1, 0}, '{22, 0, 1, 0}, '{26, 1, 1, 0}, '{30, 0, 1, 0},
             '{34, 1, 1, 0}, '{38, 1, 1, 0}, '{41, 1, 1, 0}, '{42, 1, 0, 0}};

      // 1: reset held with wvalid asserted
      rst = 1'b1; wvalid = 1'b1; wdata = 8'h77;
      repeat (3) tick();
      chk("rst_tx", int'(tx), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_wready", int'(wready), 1);
      rst = 1'b0; wvalid = 1'b0;
      repeat (8) tick();
      chk("post_rst_tx", int'(tx), 1);
      chk("post_rst_level", int'(level), 0);

      // 2: single 0xA5 frame against a constant table
      push_byte(8'hA5);
      wvalid = 1'b0;
      e = cyc;
      for (int i = 0; i < 16; i++) begin
         wait_until(e + vt[i].at);
         chk($sformatf("a5_tx@%0d", vt[i].at), int'(tx), int'(vt[i].tx));
         chk($sformatf("a5_busy@%0d", vt[i].at), int'(busy), int'(vt[i].busy));
         chk($sformatf("a5_level@%0d", vt[i].at), int'(level), vt[i].lvl);
      end
      wait_idle();

      // 3: back-to-back frames, no idle gap between stop and next start
      push_byte(8'h00);
      e = cyc;
      push_byte(8'hFF);
      wvalid = 1'b0;
      wait_until(e + 2 + FRAME - 1);
      chk("b2b_stop", int'(tx), 1);
      tick();
      chk("b2b_start2", int'(tx), 0);
      wait_until(e + 2 + FRAME + DIV);
      chk("b2b_ff_bit0", int'(tx), 1);
      wait_idle();

      // 4: overfill with wvalid held; stalled byte must still go out
      stall_seen = 0;
      for (int i = 0; i < 6; i++) push_byte(DW'(8'h10 + i * 8'h11));
      wvalid = 1'b0;
      chk("full_stall_seen", int'(stall_seen), 1);
      wait_idle();

      // 5: push and pop on the same edge at level 2, then wrap pointers
      push_byte(8'h5A);
      e = cyc;
      push_byte(8'hC3);
      push_byte(8'h81);
      wvalid = 1'b0;
      wait_until(e + 40);
      push_byte(8'h7E);
      wvalid = 1'b0;
      chk("same_edge_cyc", cyc, e + 41);
      chk("same_edge_level", int'(level), 2);
      for (int i = 0; i < 6; i++) push_byte(DW'($urandom));
      wait_idle();

      // 6: reset mid-DATA with two bytes queued
      push_byte(8'h3C);
      e = cyc;
      push_byte(8'h11);
      push_byte(8'h22);
      wvalid = 1'b0;
      wait_until(e + 2 + DIV * 3);
      chk("pre_rst_level", int'(level), 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_tx", int'(tx), 1);
      chk("midrst_level", int'(level), 0);
      chk("midrst_busy", int'(busy), 0);
      repeat (100) tick();
      chk("midrst_quiet_tx", int'(tx), 1);

      // Random traffic with random gaps
      for (int i = 0; i < 25; i++) begin
         wvalid = 1'b0;
         repeat ($urandom_range(0, 45)) tick();
         push_byte(DW'($urandom));
      end
      wait_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
